fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and control-flow stage feeding the instruction decoder.
- Holds the PC that addresses instruction memory, which returns IMData to the decoder.
- Consumes the decoder's halt/jmp/rti strobes.
- Handles one non-nesting interrupt level: saves PC and flags on entry, restores both on rti.

Parameters:
- PC_W, 8, instruction-memory address width.
- IRQ_VEC, 8'hF0, PC loaded on interrupt entry; width PC_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- halt  input  1  decoder halt strobe for the current instruction.
- jmp  input  1  decoder jump strobe for the current instruction.
- rti  input  1  decoder return-from-interrupt strobe.
- jmp_target  input  PC_W  absolute jump address, from the register file.
- flags_in  input  4  current NZCV flags register value.
- irq  input  1  interrupt request.
- pc_out  output  PC_W  instruction-memory address (registered PC).
- flags_restore  output  4  saved flags to write back on rti.
- flags_restore_en  output  1  write-enable for the flags register on rti.
- halted  output  1  core stopped.
- in_isr  output  1  interrupt service active.

Behaviour:
- One clock (clk); synchronous active-high reset (reset).
- Reset values: pc=0, state=RUN, saved_pc=0, saved_flags=0, irq pending=0.
  - Outputs after reset: halted=0, in_isr=0, flags_restore_en=0.
- Reset mid-operation overrides every other event in that cycle.
- States: RUN, ISR, HALTED, HALTED_ISR.
  - halted=1 in HALTED and HALTED_ISR.
  - in_isr=1 in ISR and HALTED_ISR.
- next_pc (combinational), in priority order:
  - jmp → jmp_target
  - otherwise pc+1, modulo 2^PC_W, so PC_W'all-ones wraps to 0.
- RUN, priority per cycle:
  - irq_take → saved_pc<=next_pc (or pc+1 if halt), saved_flags<=flags_in, pc<=IRQ_VEC, →ISR.
  - halt → pc holds, →HALTED.
  - jmp → pc<=jmp_target.
  - else pc<=pc+1.
  - rti in RUN is a NOP (pc+1); flags_restore_en stays 0.
- ISR:
  - irq ignored (no nesting).
  - rti → pc<=saved_pc, →RUN; flags_restore_en=1 combinationally that cycle, flags_restore=saved_flags.
  - halt → →HALTED_ISR.
  - jmp/increment as in RUN.
  - rti and jmp together: rti wins.
- HALTED:
  - pc holds.
  - irq_take → saved_pc<=pc+1, saved_flags<=flags_in, pc<=IRQ_VEC, →ISR.
  - Decoder strobes are ignored.
- HALTED_ISR: terminal; only reset exits.
- flags_restore = saved_flags at all times; only flags_restore_en gates its use.
- Latency: a PC change is visible on pc_out one cycle after the strobe.

Optional Feature:
- Macro FETCH_IRQ_EDGE_EN.
- Defined:
  - irq is registered.
  - A rising edge (irq=1, previous=0) sets a pending bit.
  - irq_take = pending && state∈{RUN,HALTED}.
  - pending clears on the take.
  - An edge arriving during ISR stays pending and is taken on the cycle after rti returns to RUN.
- Undefined:
  - Level-sensitive: irq_take = irq && state∈{RUN,HALTED}.
  - No pending register.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum fetch_state_t {RUN, ISR, HALTED, HALTED_ISR}
  - default PC_W
  - default IRQ_VEC
  - flags width constant (4).
- One natural sub-module, irq_detect:
  - level/edge logic and pending bit, selected by FETCH_IRQ_EDGE_EN.
  - outputs irq_take qualified by an allow input from the parent.

Test Plan:
- Reset then 5 idle cycles → pc_out 0,1,2,3,4,5; halted=0; in_isr=0.
- pc=8'h10, jmp=1, jmp_target=8'h40 → next cycle pc_out=8'h40; following cycle 8'h41.
- pc=8'hFF, no strobes → pc_out=8'h00.
- pc=8'h22, halt=1 → pc holds 8'h22, halted=1. Then irq=1 → pc_out=8'hF0, in_isr=1, saved_pc=8'h23.
- pc=8'h30, flags_in=4'b1010, irq=1 → pc_out=8'hF0. Then rti with flags_in=4'b0001 → flags_restore_en=1, flags_restore=4'b1010 that cycle; next pc_out=8'h31, in_isr=0.
- Reset asserted in ISR with pending irq (FETCH_IRQ_EDGE_EN defined) → pc_out=0, in_isr=0, pending cleared, no ISR entry afterward.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core types and defaults for the fetch stage.
// FETCH_IRQ_EDGE_EN selects edge-triggered, pending-latched interrupts.
package cpu_pkg;

    localparam int PC_W_DEF = 8;
    localparam int FLAGS_W = 4;
    localparam logic [7:0] IRQ_VEC_DEF = 8'hF0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        ISR        = 2'd1,
        HALTED     = 2'd2,
        HALTED_ISR = 2'd3
    } fetch_state_t;

    function automatic logic state_halted(input fetch_state_t s);
        return (s == HALTED) || (s == HALTED_ISR);
    endfunction

    function automatic logic state_in_isr(input fetch_state_t s);
        return (s == ISR) || (s == HALTED_ISR);
    endfunction

    function automatic logic state_can_irq(input fetch_state_t s);
        return (s == RUN) || (s == HALTED);
    endfunction

endpackage

// File: rtl/fetch_unit_irq_detect.sv
// Interrupt request qualifier: level-sensitive by default,
// rising-edge with a pending latch when FETCH_IRQ_EDGE_EN is defined.
module irq_detect (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic allow,
    output logic irq_take
);

`ifdef FETCH_IRQ_EDGE_EN
    logic irq_q;
    logic pending_q;
    logic rise;

    assign rise     = irq & ~irq_q;
    assign irq_take = pending_q & allow;

    // a fresh edge in the same cycle as a take re-arms the latch
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_q     <= irq;
            pending_q <= (pending_q & ~irq_take) | rise;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ reset;
    assign irq_take       = irq & allow;
`endif

endmodule

// File: rtl/fetch_unit.sv
// PC and control-flow stage: jump/halt/rti handling and one
// non-nesting interrupt level. FETCH_IRQ_EDGE_EN picks edge-mode irq.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter logic [PC_W-1:0] IRQ_VEC = PC_W'(IRQ_VEC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               halt,
    input  logic               jmp,
    input  logic               rti,
    input  logic [PC_W-1:0]    jmp_target,
    input  logic [FLAGS_W-1:0] flags_in,
    input  logic               irq,
    output logic [PC_W-1:0]    pc_out,
    output logic [FLAGS_W-1:0] flags_restore,
    output logic               flags_restore_en,
    output logic               halted,
    output logic               in_isr
);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_d;
    logic [PC_W-1:0]     saved_pc_q;
    logic [PC_W-1:0]     saved_pc_d;
    logic [FLAGS_W-1:0]  saved_flags_q;
    logic [FLAGS_W-1:0]  saved_flags_d;
    logic [PC_W-1:0]     pc_plus1;
    logic [PC_W-1:0]     next_pc;
    logic [PC_W-1:0]     return_pc;
    logic                irq_take;

    irq_detect u_irq (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .allow    (state_can_irq(state_q)),
        .irq_take (irq_take)
    );

    assign pc_plus1 = pc_q + 1'b1;
    assign next_pc  = jmp ? jmp_target : pc_plus1;

    // halted or halting instructions resume at the following address
    assign return_pc = (state_q == RUN && !halt) ? next_pc : pc_plus1;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        saved_pc_d    = saved_pc_q;
        saved_flags_d = saved_flags_q;
        unique case (state_q)
            RUN: begin
                if (irq_take) begin
                    saved_pc_d    = return_pc;
                    saved_flags_d = flags_in;
                    pc_d          = IRQ_VEC;
                    state_d       = ISR;
                end else if (halt) begin
                    state_d = HALTED;
                end else begin
                    pc_d = next_pc;
                end
            end
            ISR: begin
                if (rti) begin
                    pc_d    = saved_pc_q;
                    state_d = RUN;
                end else if (halt) begin
                    state_d = HALTED_ISR;
                end else begin
                    pc_d = next_pc;
                end
            end
            HALTED: begin
                if (irq_take) begin
                    saved_pc_d    = return_pc;
                    saved_flags_d = flags_in;
                    pc_d          = IRQ_VEC;
                    state_d       = ISR;
                end
            end
            HALTED_ISR: begin
                state_d = HALTED_ISR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= '0;
            saved_pc_q    <= '0;
            saved_flags_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            saved_pc_q    <= saved_pc_d;
            saved_flags_q <= saved_flags_d;
        end
    end

    assign pc_out           = pc_q;
    assign flags_restore    = saved_flags_q;
    assign flags_restore_en = (state_q == ISR) && rti;
    assign halted           = state_halted(state_q);
    assign in_isr           = state_in_isr(state_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven check of fetch_unit: each record drives one cycle and
// gives the expected combinational restore outputs and next registered state.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic       clk;
    logic       reset;
    logic       halt;
    logic       jmp;
    logic       rti;
    logic [7:0] jmp_target;
    logic [3:0] flags_in;
    logic       irq;
    logic [7:0] pc_out;
    logic [3:0] flags_restore;
    logic       flags_restore_en;
    logic       halted;
    logic       in_isr;

    int checks;
    int failures;

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .halt             (halt),
        .jmp              (jmp),
        .rti              (rti),
        .jmp_target       (jmp_target),
        .flags_in         (flags_in),
        .irq              (irq),
        .pc_out           (pc_out),
        .flags_restore    (flags_restore),
        .flags_restore_en (flags_restore_en),
        .halted           (halted),
        .in_isr           (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       hlt;
        logic       jp;
        logic       rt;
        logic       iq;
        logic [7:0] tgt;
        logic [3:0] flg;
        logic [7:0] e_pc;
        logic       e_halted;
        logic       e_isr;
        logic       e_fre;
        logic [3:0] e_fr;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(
        input logic rst, input logic hlt, input logic jp,
        input logic rt, input logic iq,
        input logic [7:0] tgt, input logic [3:0] flg,
        input logic [7:0] e_pc, input logic e_h, input logic e_i,
        input logic e_fre, input logic [3:0] e_fr
    );
        vec_t r;
        r.rst = rst; r.hlt = hlt; r.jp = jp; r.rt = rt; r.iq = iq;
        r.tgt = tgt; r.flg = flg;
        r.e_pc = e_pc; r.e_halted = e_h; r.e_isr = e_i;
        r.e_fre = e_fre; r.e_fr = e_fr;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; halt = 1'b0; jmp = 1'b0; rti = 1'b0;
        jmp_target = 8'h00; flags_in = 4'h0; irq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // rst hlt jmp rti irq tgt flg | pc h isr fre fr
        v(1,0,0,0,0, 8'h00,4'h0, 8'h00,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h01,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h02,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h03,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h04,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h05,0,0,0,4'h0);
        v(0,0,1,0,0, 8'h10,4'h0, 8'h10,0,0,0,4'h0);
        v(0,0,1,0,0, 8'h40,4'h0, 8'h40,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h41,0,0,0,4'h0);
        v(0,0,1,0,0, 8'hFF,4'h0, 8'hFF,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h00,0,0,0,4'h0);
        v(0,0,0,1,0, 8'h00,4'h0, 8'h01,0,0,0,4'h0);
        v(0,0,1,0,0, 8'h22,4'h0, 8'h22,0,0,0,4'h0);
        v(0,1,0,0,0, 8'h00,4'h0, 8'h22,1,0,0,4'h0);
        v(0,0,1,0,0, 8'h99,4'h0, 8'h22,1,0,0,4'h0);
        v(0,0,0,1,0, 8'h00,4'h0, 8'h22,1,0,0,4'h0);
        v(1,0,0,0,0, 8'h00,4'h0, 8'h00,0,0,0,4'h0);
`ifndef FETCH_IRQ_EDGE_EN
        v(0,0,1,0,0, 8'h22,4'h0, 8'h22,0,0,0,4'h0);
        v(0,1,0,0,0, 8'h00,4'h0, 8'h22,1,0,0,4'h0);
        v(0,0,0,0,1, 8'h00,4'h5, 8'hF0,0,1,0,4'h0);
        v(0,0,0,0,1, 8'h00,4'h0, 8'hF1,0,1,0,4'h5);
        v(0,0,0,1,0, 8'h00,4'h0, 8'h23,0,0,1,4'h5);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h24,0,0,0,4'h5);
        v(0,0,1,0,0, 8'h30,4'h0, 8'h30,0,0,0,4'h5);
        v(0,0,0,0,1, 8'h00,4'hA, 8'hF0,0,1,0,4'h5);
        v(0,0,1,0,0, 8'h50,4'h0, 8'h50,0,1,0,4'hA);
        v(0,0,1,1,0, 8'h77,4'h1, 8'h31,0,0,1,4'hA);
        v(0,0,1,0,1, 8'h60,4'hC, 8'hF0,0,1,0,4'hA);
        v(0,0,0,1,0, 8'h00,4'h0, 8'h60,0,0,1,4'hC);
        v(0,1,0,0,1, 8'h00,4'h6, 8'hF0,0,1,0,4'hC);
        v(0,1,0,1,0, 8'h00,4'h0, 8'h61,0,0,1,4'h6);
        v(0,0,0,0,1, 8'h00,4'hF, 8'hF0,0,1,0,4'h6);
        v(0,1,0,0,0, 8'h00,4'h0, 8'hF0,1,1,0,4'hF);
        v(0,0,0,1,0, 8'h00,4'h0, 8'hF0,1,1,0,4'hF);
        v(0,0,1,0,1, 8'h33,4'h0, 8'hF0,1,1,0,4'hF);
        v(1,0,1,0,1, 8'h33,4'h0, 8'h00,0,0,0,4'hF);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h01,0,0,0,4'h0);
`else
        v(0,0,0,0,1, 8'h00,4'h0, 8'h01,0,0,0,4'h0);
        v(0,0,0,0,1, 8'h00,4'h3, 8'hF0,0,1,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'hF1,0,1,0,4'h3);
        v(0,0,0,0,1, 8'h00,4'h0, 8'hF2,0,1,0,4'h3);
        v(0,0,0,1,0, 8'h00,4'h0, 8'h02,0,0,1,4'h3);
        v(0,0,0,0,0, 8'h00,4'h9, 8'hF0,0,1,0,4'h3);
        v(0,0,0,0,0, 8'h00,4'h0, 8'hF1,0,1,0,4'h9);
        v(0,0,0,0,1, 8'h00,4'h0, 8'hF2,0,1,0,4'h9);
        v(1,0,0,0,0, 8'h00,4'h0, 8'h00,0,0,0,4'h9);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h01,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h02,0,0,0,4'h0);
        v(0,0,0,0,0, 8'h00,4'h0, 8'h03,0,0,0,4'h0);
        v(0,0,0,0,1, 8'h00,4'h0, 8'h04,0,0,0,4'h0);
        v(0,0,0,0,1, 8'h00,4'h2, 8'hF0,0,1,0,4'h0);
        v(0,0,0,0,1, 8'h00,4'h0, 8'hF1,0,1,0,4'h2);
        v(0,0,0,1,1, 8'h00,4'h0, 8'h05,0,0,1,4'h2);
        v(0,0,0,0,1, 8'h00,4'h0, 8'h06,0,0,0,4'h2);
`endif

        foreach (vecs[i]) begin
            reset      = vecs[i].rst;
            halt       = vecs[i].hlt;
            jmp        = vecs[i].jp;
            rti        = vecs[i].rt;
            irq        = vecs[i].iq;
            jmp_target = vecs[i].tgt;
            flags_in   = vecs[i].flg;
            #2;
            chk($sformatf("v%0d_fre", i), {7'd0, flags_restore_en},
                {7'd0, vecs[i].e_fre});
            chk($sformatf("v%0d_fr", i), {4'd0, flags_restore},
                {4'd0, vecs[i].e_fr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc_out, vecs[i].e_pc);
            chk($sformatf("v%0d_halted", i), {7'd0, halted},
                {7'd0, vecs[i].e_halted});
            chk($sformatf("v%0d_in_isr", i), {7'd0, in_isr},
                {7'd0, vecs[i].e_isr});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
